game_flow_ctrl: RTL

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_if.sv | 30 +++
 rtl/game_flow_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/game_flow_if.sv
// Button, game-logic and status signals of the game flow controller.
// master drives the buttons and round results; slave is the controller.
interface game_flow_if #(
  parameter int NUM_MAPS = 2
);
  localparam int MAP_W = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;

  logic                help;
  logic                menu;
  logic                select_map;
  logic [NUM_MAPS-1:0] map_req;
  logic                pause;
  logic                win;
  logic                winner;
  logic [2:0]          state;
  logic [MAP_W-1:0]    map_id;
  logic                game_active;
  logic                game_start;
  logic                winner_q;

  modport master (
    output help, menu, select_map, map_req, pause, win, winner,
    input  state, map_id, game_active, game_start, winner_q
  );

  modport slave (
    input  help, menu, select_map, map_req, pause, win, winner,
    output state, map_id, game_active, game_start, winner_q
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Menu / map-select / round / result sequencer driven by button rising edges.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
//
// state  | code | meaning
// IDLE   | 000  | main menu
// HELP   | 001  | help screen
// SELECT | 010  | choosing a map
// GAME   | 011  | round running
// PAUSE  | 100  | round frozen (GAME_PAUSE_EN only, otherwise illegal)
// END    | 101  | result screen, leaves on menu or timeout
module game_flow_ctrl #(
  parameter int NUM_MAPS    = 2,
  parameter int END_TIMEOUT = 100_000_000
) (
  input logic       clk,
  input logic       rst,
  game_flow_if.slave bus
);
  localparam int MAP_W = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_HELP   = 3'b001,
    S_SELECT = 3'b010,
    S_GAME   = 3'b011,
    S_PAUSE  = 3'b100,
    S_END    = 3'b101
  } state_t;

  state_t              state_q, state_d;
  logic                help_q, menu_q, sel_q;
  logic [NUM_MAPS-1:0] map_q;
  logic                help_e, menu_e, sel_e;
  logic [NUM_MAPS-1:0] map_e;
  logic                pause_e;
  logic [MAP_W-1:0]    map_pick, map_id_q;
  logic                winner_r, game_start_q;
  logic                load_map, load_win, start_d;
  logic                to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      help_q <= 1'b0;
      menu_q <= 1'b0;
      sel_q  <= 1'b0;
      map_q  <= '0;
    end else begin
      help_q <= bus.help;
      menu_q <= bus.menu;
      sel_q  <= bus.select_map;
      map_q  <= bus.map_req;
    end
  end

  assign help_e = bus.help & ~help_q;
  assign menu_e = bus.menu & ~menu_q;
  assign sel_e  = bus.select_map & ~sel_q;
  assign map_e  = bus.map_req & ~map_q;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_q <= 1'b0;
    else     pause_q <= bus.pause;
  end
  assign pause_e = bus.pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign pause_e      = 1'b0;
`endif

  // lowest-index map edge wins
  always_comb begin
    map_pick = '0;
    for (int i = NUM_MAPS - 1; i >= 0; i--) begin
      if (map_e[i]) map_pick = MAP_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_map = 1'b0;
    load_win = 1'b0;
    start_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (help_e)     state_d = S_HELP;
        else if (sel_e) state_d = S_SELECT;
      end
      S_HELP: begin
        if (menu_e) state_d = S_IDLE;
      end
      S_SELECT: begin
        if (|map_e) begin
          state_d  = S_GAME;
          load_map = 1'b1;
          start_d  = 1'b1;
        end else if (menu_e) begin
          state_d = S_IDLE;
        end
      end
      S_GAME: begin
        if (bus.win) begin
          state_d  = S_END;
          load_win = 1'b1;
        end else if (pause_e) begin
          state_d = S_PAUSE;
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (pause_e)     state_d = S_GAME;
        else if (menu_e) state_d = S_IDLE;
      end
`endif
      S_END: begin
        if (menu_e || to_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // result-screen timeout; absent entirely when END_TIMEOUT is 0
  if (END_TIMEOUT > 0) begin : g_to
    localparam int CNT_W = $clog2(END_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC = CNT_W'(END_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         cnt_q <= '0;
      else if (state_q == S_END && state_d == S_END)   cnt_q <= cnt_q + 1'b1;
      else                                             cnt_q <= '0;
    end
    assign to_hit = (state_q == S_END) && (cnt_q == TC);
  end else begin : g_no_to
    assign to_hit = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_id_q     <= '0;
      winner_r     <= 1'b0;
      game_start_q <= 1'b0;
    end else begin
      if (load_map) map_id_q <= map_pick;
      if (load_win) winner_r <= bus.winner;
      game_start_q <= start_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.map_id      = map_id_q;
  assign bus.game_active = (state_q == S_GAME);
  assign bus.game_start  = game_start_q;
  assign bus.winner_q    = winner_r;
endmodule
